design_switch_ctrl: RTL
=======================

// Module: design_switch_ctrl
// PURPOSE
// Sequencer that drives the 4-bit design_select consumed by the top-level design mux.
// Accepts a new design id over a valid/ready handshake and performs a glitch-safe switch:
//  1. isolates the GPIOs (all pins forced to input);
//  2. holds the design reset low while the select changes;
//  3. releases the reset, then restores the GPIOs.
// Sits between the management/LA command source and the integrated design mux.
// PARAMETERS
// NUM_DESIGNS   12  highest valid design id (ids 1..NUM_DESIGNS valid, 0 = none selected)
// GUARD_CYCLES  2   cycles spent in ISOLATE and in SETTLE (>=1)
// RST_CYCLES    4   cycles the design reset is held low in RESET (>=1)
// PORTS
// clk          in   1  system clock
// n_rst        in   1  asynchronous active-low reset
// req_valid    in   1  switch request valid
// req_id       in   4  requested design id
// req_ready    out  1  high only in IDLE; request accepted when req_valid & req_ready at posedge
// design_select out 4  registered select to design mux
// sel_n_rst    out  1  active-low reset for the selected design (ANDed with n_rst downstream)
// gpio_safe    out  1  1 = force all gpio_oeb high and gpio_out low at the mux
// switch_done  out  1  one-cycle pulse when a switch sequence completes
// busy         out  1  high in every state except IDLE
// BEHAVIOUR
// - Reset values (asynchronous, while n_rst low):
//   - design_select=0, sel_n_rst=0, gpio_safe=1, switch_done=0, state=INIT.
// - INIT: lasts 1 cycle, then IDLE.
//   - sel_n_rst and gpio_safe stay registered at reset values during INIT.
//   - On entering IDLE: sel_n_rst=1, gpio_safe=0.
// - IDLE: req_ready=1. On accept, latch id into pending_id and branch:
//   - pending_id == design_select: no sequence; switch_done pulses next cycle; stay IDLE.
//   - otherwise -> ISOLATE: gpio_safe=1.
// - ISOLATE (GUARD_CYCLES): on exit, design_select<=pending_id and sel_n_rst<=0, same edge -> RESET.
// - RESET (RST_CYCLES): sel_n_rst=0. On exit sel_n_rst<=1 -> SETTLE.
// - SETTLE (GUARD_CYCLES): on exit gpio_safe<=0, switch_done<=1 (1 cycle) -> IDLE.
// - Latency: accept at edge T; switch_done high in cycle T+2*GUARD_CYCLES+RST_CYCLES.
//   - Defaults: 8 cycles.
// - design_select changes only while sel_n_rst=0 and gpio_safe=1; never changes otherwise.
// - req_valid with req_ready=0 is ignored, not queued; the requester must hold it until accepted.
// - One dwell counter, width $clog2(max(GUARD_CYCLES,RST_CYCLES)+1).
//   - Reloaded on every state entry; no wrap.
// - id 0 is legal: full sequence, ending with design_select=0 (all designs deselected).
// - n_rst asserted mid-sequence: immediate return to the reset values above; pending request lost.
// CONFIGURATION
// Macro DESIGN_SWITCH_ERR_EN:
// - Defined: adds output req_err (1 bit, reset 0).
//   - Accepted req_id > NUM_DESIGNS pulses req_err for 1 cycle and is dropped.
//   - No state change, design_select unchanged, no switch_done.
// - Undefined: no req_err port. An out-of-range id is treated as id 0.
//   - Full sequence runs, ending with design_select=0.
// TESTING (GUARD_CYCLES=2, RST_CYCLES=4)
// 1. Reset release:
//    - design_select=0, sel_n_rst=0, gpio_safe=1 during reset.
//    - 1 cycle after release: sel_n_rst=1, gpio_safe=0, req_ready=1.
// 2. Request id 5 from idle:
//    - gpio_safe=1 for 8 cycles.
//    - sel_n_rst=0 for exactly 4 cycles; design_select=5 from the first low cycle onward.
//    - switch_done at accept+8; req_ready=0 throughout.
// 3. Request id 5 again while select=5: switch_done next cycle; sel_n_rst and gpio_safe never toggle.
// 4. Request id 9 while busy: ignored.
//    - Held req_valid accepted on the first IDLE cycle, then the full sequence runs to select=9.
// 5. id 14:
//    - With DESIGN_SWITCH_ERR_EN: req_err pulse, select unchanged.
//    - Without: sequence ends at select=0.
// 6. Assert n_rst during RESET: outputs return to reset values asynchronously.
//    - After release: select=0, IDLE.

Source files
------------

// File: rtl/design_switch_ctrl.sv
// design_switch_ctrl
//   Drives the 4-bit design_select used by the top-level design mux. A new
//   design id is taken over a valid/ready handshake, and the switch is made
//   glitch-safe: the GPIOs are isolated, the design reset is held low while
//   the select changes, then the reset is released and the GPIOs restored.
//
// Ports
//   clk            in   system clock
//   n_rst          in   asynchronous active-low reset
//   req_valid      in   switch request valid
//   req_id[3:0]    in   requested design id (0 = none selected)
//   req_ready      out  high only in IDLE
//   design_select  out  registered select to the design mux
//   sel_n_rst      out  active-low reset for the selected design
//   gpio_safe      out  1 = force gpio_oeb high / gpio_out low at the mux
//   switch_done    out  one-cycle pulse when a request completes
//   req_err        out  (DESIGN_SWITCH_ERR_EN only) pulse on out-of-range id
//   busy           out  high in every state except IDLE
//
// Build option
//   DESIGN_SWITCH_ERR_EN : out-of-range ids are rejected with req_err. When
//   it is undefined, an out-of-range id is handled as id 0.
module design_switch_ctrl #(
   parameter int NUM_DESIGNS  = 12,
   parameter int GUARD_CYCLES = 2,
   parameter int RST_CYCLES   = 4
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       req_valid,
   input  logic [3:0] req_id,
   output logic       req_ready,
   output logic [3:0] design_select,
   output logic       sel_n_rst,
   output logic       gpio_safe,
   output logic       switch_done,
`ifdef DESIGN_SWITCH_ERR_EN
   output logic       req_err,
`endif
   output logic       busy
);

   localparam int MAXC = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] GUARD_LD = CW'(GUARD_CYCLES - 1);
   localparam logic [CW-1:0] RST_LD   = CW'(RST_CYCLES - 1);
   localparam logic [3:0]    MAX_ID   = 4'(NUM_DESIGNS);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISO, S_RST, S_SET} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    pend_q, pend_d;
   logic [3:0]    sel_q, sel_d;
   logic          srst_q, srst_d;
   logic          safe_q, safe_d;
   logic          done_q, done_d;
`ifdef DESIGN_SWITCH_ERR_EN
   logic          err_q, err_d;
`endif

   logic       oor;
   logic       drop;    // accepted request is rejected outright
   logic [3:0] id_eff;  // id actually used for the switch
   logic       last;    // final cycle of the current dwell

   assign oor  = req_id > MAX_ID;
   assign last = (cnt_q == '0);
`ifdef DESIGN_SWITCH_ERR_EN
   assign drop   = oor;
   assign id_eff = req_id;
`else
   assign drop   = 1'b0;
   assign id_eff = oor ? 4'd0 : req_id;
`endif

   // State register plus the registered outputs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
         pend_q  <= '0;
         sel_q   <= '0;
         srst_q  <= 1'b0;
         safe_q  <= 1'b1;
         done_q  <= 1'b0;
`ifdef DESIGN_SWITCH_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         sel_q   <= sel_d;
         srst_q  <= srst_d;
         safe_q  <= safe_d;
         done_q  <= done_d;
`ifdef DESIGN_SWITCH_ERR_EN
         err_q   <= err_d;
`endif
      end
   end

   // Next state; the dwell counter is reloaded on every state entry and
   // counts down to zero, the exit condition.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      case (state_q)
         S_INIT: state_d = S_IDLE;
         S_IDLE: begin
            if (req_valid && !drop) begin
               pend_d = id_eff;
               if (id_eff != sel_q) begin
                  state_d = S_ISO;
                  cnt_d   = GUARD_LD;
               end
            end
         end
         S_ISO: begin
            if (last) begin
               state_d = S_RST;
               cnt_d   = RST_LD;
            end else cnt_d = cnt_q - 1'b1;
         end
         S_RST: begin
            if (last) begin
               state_d = S_SET;
               cnt_d   = GUARD_LD;
            end else cnt_d = cnt_q - 1'b1;
         end
         S_SET: begin
            if (last) state_d = S_IDLE;
            else      cnt_d = cnt_q - 1'b1;
         end
         default: state_d = S_INIT;
      endcase
   end

   // Outputs. The select only moves on the ISOLATE->RESET edge, where
   // gpio_safe is already high and sel_n_rst drops on the same edge.
   always_comb begin
      sel_d  = sel_q;
      srst_d = srst_q;
      safe_d = safe_q;
      done_d = 1'b0;
`ifdef DESIGN_SWITCH_ERR_EN
      err_d  = 1'b0;
`endif
      req_ready = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      case (state_q)
         S_INIT: begin
            srst_d = 1'b1;
            safe_d = 1'b0;
         end
         S_IDLE: begin
            if (req_valid) begin
               if (drop) begin
`ifdef DESIGN_SWITCH_ERR_EN
                  err_d = 1'b1;
`endif
               end else if (id_eff == sel_q) done_d = 1'b1;
               else safe_d = 1'b1;
            end
         end
         S_ISO: begin
            if (last) begin
               sel_d  = pend_q;
               srst_d = 1'b0;
            end
         end
         S_RST: if (last) srst_d = 1'b1;
         S_SET: begin
            if (last) begin
               safe_d = 1'b0;
               done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign design_select = sel_q;
   assign sel_n_rst     = srst_q;
   assign gpio_safe     = safe_q;
   assign switch_done   = done_q;
`ifdef DESIGN_SWITCH_ERR_EN
   assign req_err       = err_q;
`endif

endmodule
